// File: rtl/uart_frame_core.sv
// uart_frame_core: byte framing between a UART byte engine and the mining core
// Assembles HEADER_BYTES received bytes into header_data (first byte at the MSBs),
// dropping a partial frame after RX_TIMEOUT idle clocks. Buffers result words in a
// FIFO_DEPTH-entry FIFO and sends each one MSB-first through a start/busy handshake.
// Ports:
//   clock, reset (sync, active-low)
//   rx_byte, rx_valid                      : received byte stream
//   header_data, header_valid, rx_frame_err : assembled header, update pulse, error pulse
//   result_data, result_push               : result word enqueue
//   result_full, result_drop               : FIFO full flag, rejected-push pulse
//   tx_byte, tx_start, tx_busy, tx_active  : transmitter handshake and word-in-flight flag
// Optional: define UART_FRAME_CKSUM_EN to add an XOR checksum byte to every RX frame
// (checked) and every TX word (appended).
module uart_frame_core #(
  parameter int HEADER_BYTES = 80,
  parameter int RESULT_BYTES = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int RX_TIMEOUT   = 1000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic                      rx_frame_err,
  input  logic [RESULT_BYTES*8-1:0] result_data,
  input  logic                      result_push,
  output logic                      result_full,
  output logic                      result_drop,
  output logic [7:0]                tx_byte,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      tx_active
);
`ifdef UART_FRAME_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int HW = HEADER_BYTES * 8;
  localparam int FL = HEADER_BYTES + CK;
  localparam int RW = RESULT_BYTES * 8;
  localparam int WB = RESULT_BYTES + CK;
  localparam int SW = WB * 8;
  localparam int BW = $clog2(FL + 1);
  localparam int TW = $clog2(RX_TIMEOUT);
  localparam int CW = $clog2(WB + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] asm_q, asm_n;
  logic          last, hdr_byte;
  assign asm_n = (asm_q << 8) | HW'(rx_byte);
  assign last  = bcnt == BW'(FL - 1);
`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] rx_x;
  // The trailing checksum byte is compared, never shifted into the header.
  assign hdr_byte = bcnt < BW'(HEADER_BYTES);
  always_ff @(posedge clock) begin
    if (!reset) rx_x <= '0;
    else if (rx_valid && hdr_byte) rx_x <= (bcnt == '0 ? 8'h00 : rx_x) ^ rx_byte;
  end
`else
  assign hdr_byte = 1'b1;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      bcnt         <= '0;
      tcnt         <= '0;
      asm_q        <= '0;
      header_data  <= '0;
      header_valid <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rx_valid) begin
        tcnt <= '0;
        if (hdr_byte) asm_q <= asm_n;
        if (last) begin
          bcnt <= '0;
`ifdef UART_FRAME_CKSUM_EN
          if (rx_byte == rx_x) begin
            header_data  <= asm_q;
            header_valid <= 1'b1;
          end else rx_frame_err <= 1'b1;
`else
          header_data  <= asm_n;
          header_valid <= 1'b1;
`endif
        end else bcnt <= bcnt + 1'b1;
      end else if (bcnt != '0) begin
        if (tcnt == TW'(RX_TIMEOUT - 1)) begin
          bcnt         <= '0;
          tcnt         <= '0;
          rx_frame_err <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
      end
    end
  end
  state_t        state, state_n;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   occ, occ_n;
  logic [RW-1:0] head;
  logic [SW-1:0] shift, load_v;
  logic [CW-1:0] cnt;
  logic [7:0]    tx_q;
  logic          pop, push_ok;
  assign head    = mem[rp];
  assign pop     = state == LOAD;
  // A full FIFO still accepts a push in the cycle the head is popped.
  assign push_ok = result_push && (!result_full || pop);
  assign occ_n   = occ + (AW+1)'(push_ok) - (AW+1)'(pop);
`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] hx;
  always_comb begin
    hx = 8'h00;
    for (int i = 0; i < RESULT_BYTES; i++) hx = hx ^ head[i*8 +: 8];
  end
  assign load_v = {head, hx};
`else
  assign load_v = head;
`endif
  always_ff @(posedge clock) begin
    if (push_ok) mem[wp] <= result_data;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp          <= '0;
      rp          <= '0;
      occ         <= '0;
      result_full <= 1'b0;
      result_drop <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      occ         <= occ_n;
      result_full <= occ_n == (AW+1)'(FIFO_DEPTH);
      result_drop <= result_push && !push_ok;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (occ != '0) state_n = LOAD;
      LOAD:    state_n = START;
      START:   state_n = WAIT_HI;
      WAIT_HI: if (tx_busy) state_n = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_n = cnt == CW'(1) ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift <= '0;
      cnt   <= '0;
      tx_q  <= '0;
    end else begin
      if (state == LOAD) begin
        shift <= load_v;
        cnt   <= CW'(WB);
      end
      if (state == START) tx_q <= shift[SW-1 -: 8];
      if (state == WAIT_LO && !tx_busy) begin
        shift <= shift << 8;
        cnt   <= cnt - 1'b1;
      end
    end
  end
  // tx_byte shows the outgoing byte during START and holds it until the next START.
  assign tx_start  = state == START;
  assign tx_active = state != IDLE;
  assign tx_byte   = tx_start ? shift[SW-1 -: 8] : tx_q;
endmodule
